// File: rtl/sr_drive_ctrl_pkg.sv
// rtl/sr_drive_ctrl_pkg.sv - shared types and the SR excitation rule
package sr_drive_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        CHECK,
        RESP_OK,
        RESP_ERR
    } state_t;

    typedef enum logic [1:0] {
        EX_HOLD  = 2'b00,
        EX_RESET = 2'b01,
        EX_SET   = 2'b10
    } excite_t;

    // Never yields 2'b11, so s=r=1 cannot reach the bank from this rule.
    function automatic excite_t to_excite(input logic tgt, input logic q, input logic msk);
        if (!msk || (tgt == q)) begin
            return EX_HOLD;
        end else if (tgt) begin
            return EX_SET;
        end else begin
            return EX_RESET;
        end
    endfunction

endpackage

// File: rtl/sr_drive_ctrl_if.sv
// rtl/sr_drive_ctrl_if.sv - command handshake and SR bank drive/feedback bundle
interface sr_drive_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [WIDTH-1:0] cmd_mask;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q_fb;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_data, cmd_mask, q_fb,
        input  cmd_ready, s, r, done, err
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_mask, q_fb,
        output cmd_ready, s, r, done, err
    );
endinterface

// File: rtl/sr_drive_ctrl_excite.sv
// rtl/sr_drive_ctrl_excite.sv - per-lane combinational map of tgt/q/msk to s/r
module sr_excite
    import sr_drive_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_tgt,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_msk,
    output logic [WIDTH-1:0] o_s,
    output logic [WIDTH-1:0] o_r
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        excite_t w_ex;
        assign w_ex   = to_excite(i_tgt[i], i_q[i], i_msk[i]);
        assign o_s[i] = w_ex[1];
        assign o_r[i] = w_ex[0];
    end

endmodule

// File: rtl/sr_drive_ctrl.sv
// rtl/sr_drive_ctrl.sv - command-driven SR bank excitation controller with match check and timeout
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    sr_drive_ctrl_if.slave bus
);

    localparam int             CW     = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TO_MAX = CW'(TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_msk;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_r;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             r_ready;
    logic             r_done;
    logic             r_err;
    logic             w_accept;
    logic             w_match;

    // Excitation is formed from q_fb as seen on the accept edge, then registered into DRIVE.
    sr_excite #(.WIDTH(WIDTH)) u_excite (
        .i_tgt (bus.cmd_data),
        .i_q   (bus.q_fb),
        .i_msk (bus.cmd_mask),
        .o_s   (w_s),
        .o_r   (w_r)
    );

    assign w_accept   = bus.cmd_valid && r_ready;
    assign w_match    = ((bus.q_fb ^ r_tgt) & r_msk) == '0;
    assign w_cnt_next = (r_cnt == TO_MAX) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_next = DRIVE;
            DRIVE:    w_next = CHECK;
            CHECK: begin
                if (w_match) begin
                    w_next = RESP_OK;
                end else if (w_cnt_next == TO_MAX) begin
                    w_next = RESP_ERR;
                end
            end
            RESP_OK:  w_next = IDLE;
            RESP_ERR: w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Status outputs are registered copies of the next state so they line up with the state they flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_s     <= '0;
            r_r     <= '0;
            r_tgt   <= '0;
            r_msk   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == IDLE);
            r_done  <= (w_next == RESP_OK);
            r_err   <= (w_next == RESP_ERR);
            r_s     <= w_accept ? w_s : '0;
            r_r     <= w_accept ? w_r : '0;
            if (w_accept) begin
                r_tgt <= bus.cmd_data;
                r_msk <= bus.cmd_mask;
            end
            if (r_state == DRIVE) begin
                r_cnt <= '0;
            end else if ((r_state == CHECK) && !w_match) begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.s         = r_s;
    assign bus.r         = r_r;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb/tb_sr_drive_ctrl.sv - randomized self-checking bench with SR bank and stuck-q feedback model
module tb_sr_drive_ctrl;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] stuck0;
    int               total;
    int               bad;

    sr_drive_ctrl_if #(.WIDTH(WIDTH)) bus ();

    sr_drive_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SR flip-flop bank; stuck0 lanes read back as 0 regardless of drive
    always @(posedge clk) bank_q <= (bank_q | bus.s) & ~bus.r;
    assign bus.q_fb = bank_q & ~stuck0;

    always @(negedge clk) begin
        total++;
        if ((bus.s & bus.r) !== '0) begin
            bad++;
            $display("FAIL sr_exclusive t=%0t s=%h r=%h required s&r=00", $time, bus.s, bus.r);
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_wait actual=%b required=1", name, bus.cmd_ready);
        end
    endtask

    // Higher-level model: expected drive, final q, and the cycle/kind of the response.
    task automatic run_cmd(input logic [WIDTH-1:0] data, input logic [WIDTH-1:0] mask,
                           input bit hold_valid, input string name);
        logic [WIDTH-1:0] q0, exp_s, exp_r, q_end;
        bit               ok;
        int               resp_cyc, last;
        wait_ready(name);
        q0    = bank_q & ~stuck0;
        exp_s = data & ~q0 & mask;
        exp_r = ~data & q0 & mask;
        q_end = ((q0 & ~mask) | (data & mask)) & ~stuck0;
        ok    = ((q_end ^ data) & mask) == '0;
        resp_cyc = ok ? 3 : 2 + TIMEOUT;
        last  = resp_cyc + 1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = data;
        bus.cmd_mask  = mask;
        @(posedge clk);
        #1;
        if (hold_valid) begin
            bus.cmd_data = $urandom;
            bus.cmd_mask = $urandom;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            total += 5;
            if (bus.s !== ((k == 1) ? exp_s : '0)) begin
                bad++;
                $display("FAIL %s s c%0d actual=%h required=%h", name, k, bus.s, (k == 1) ? exp_s : '0);
            end
            if (bus.r !== ((k == 1) ? exp_r : '0)) begin
                bad++;
                $display("FAIL %s r c%0d actual=%h required=%h", name, k, bus.r, (k == 1) ? exp_r : '0);
            end
            if (bus.done !== (ok && k == resp_cyc)) begin
                bad++;
                $display("FAIL %s done c%0d actual=%b required=%b", name, k, bus.done, ok && k == resp_cyc);
            end
            if (bus.err !== (!ok && k == resp_cyc)) begin
                bad++;
                $display("FAIL %s err c%0d actual=%b required=%b", name, k, bus.err, !ok && k == resp_cyc);
            end
            if (bus.cmd_ready !== (k == last)) begin
                bad++;
                $display("FAIL %s ready c%0d actual=%b required=%b", name, k, bus.cmd_ready, k == last);
            end
        end
        bus.cmd_valid = 1'b0;
        total++;
        if (bus.q_fb !== q_end) begin
            bad++;
            $display("FAIL %s q_end actual=%h required=%h", name, bus.q_fb, q_end);
        end
    endtask

    task automatic check_quiet(input string name, input logic exp_ready);
        total += 5;
        if (bus.s !== '0) begin bad++; $display("FAIL %s s actual=%h required=00", name, bus.s); end
        if (bus.r !== '0) begin bad++; $display("FAIL %s r actual=%h required=00", name, bus.r); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL %s done actual=%b required=0", name, bus.done); end
        if (bus.err !== 1'b0) begin bad++; $display("FAIL %s err actual=%b required=0", name, bus.err); end
        if (bus.cmd_ready !== exp_ready) begin
            bad++;
            $display("FAIL %s ready actual=%b required=%b", name, bus.cmd_ready, exp_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset_hold", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("reset_release", 1'b1);
    endtask

    task automatic test_directed();
        run_cmd(8'hA5, 8'hFF, 1'b0, "set_a5");
        run_cmd(8'h0F, 8'hFF, 1'b0, "a5_to_0f_prep");
        bank_q = 8'hA5;
        run_cmd(8'h0F, 8'hFF, 1'b0, "a5_to_0f");
        bank_q = 8'hA5;
        run_cmd(8'h00, 8'h0F, 1'b0, "clr_low_nibble");
        run_cmd(8'hA0, 8'hFF, 1'b0, "data_eq_q");
        run_cmd(8'h5A, 8'h00, 1'b0, "mask_zero");
    endtask

    task automatic test_stuck();
        bank_q = 8'h00;
        stuck0 = 8'h08;
        run_cmd(8'h08, 8'hFF, 1'b0, "stuck_lane3");
        bank_q = bank_q & ~stuck0;
        stuck0 = '0;
    endtask

    task automatic test_reset_mid();
        wait_ready("reset_mid");
        stuck0 = 8'h01;
        bank_q = 8'h00;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h01;
        bus.cmd_mask  = 8'hFF;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_quiet("reset_mid_now", 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_quiet("reset_mid_hold", 1'b0);
        end
        rst_n = 1'b1;
        bank_q = bank_q & ~stuck0;
        stuck0 = '0;
        @(negedge clk);
        check_quiet("reset_mid_release", 1'b1);
        run_cmd(8'h3C, 8'hFF, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                stuck0 = 8'(1 << $urandom_range(0, WIDTH - 1));
            end
            run_cmd(8'($urandom), ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                    1'($urandom_range(0, 1)), "random");
            bank_q = bank_q & ~stuck0;
            stuck0 = '0;
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(8'hFF, 8'hFF, 1'b1, "b2b_0");
        run_cmd(8'h00, 8'hF0, 1'b1, "b2b_1");
        run_cmd(8'h81, 8'h81, 1'b0, "b2b_2");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bank_q = '0;
        stuck0 = '0;
        rst_n  = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.cmd_mask  = '0;
        test_reset();
        test_directed();
        test_stuck();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/sr_drive_ctrl.md
# sr_drive_ctrl

Command-driven excitation controller for a bank of SR flip-flops; it is the driving end of the s/r interface. It accepts a target word over a valid/ready handshake and converts each masked lane into a single-cycle set, reset or hold pulse, using the SR excitation table against the bank's current q. It then checks the q feedback until the lanes match, and reports done or a timeout error. It is never allowed to issue the illegal s=r=1 combination.

## Interface
- WIDTH, 8, number of SR flip-flop lanes driven
- TIMEOUT, 4, maximum CHECK cycles before err (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command (high only in IDLE)
- cmd_data  in  WIDTH  target q value per lane
- cmd_mask  in  WIDTH  1 = lane participates, 0 = lane held
- s  out  WIDTH  set drive to SR bank, registered
- r  out  WIDTH  reset drive to SR bank, registered
- q_fb  in  WIDTH  q of SR bank
- done  out  1  one-cycle pulse: command completed, masked lanes match
- err  out  1  one-cycle pulse: masked lanes failed to match within TIMEOUT

## Operation
- FSM states and transitions:
  - IDLE: on cmd_valid && cmd_ready, latch cmd_data→tgt and cmd_mask→msk, then go to DRIVE.
  - DRIVE: s/r carry the excitation for exactly one cycle, then go to CHECK.
  - CHECK: if ((q_fb ^ tgt) & msk) == 0, go to RESP_OK. Otherwise increment cnt; when cnt reaches TIMEOUT, go to RESP_ERR.
  - RESP_OK: done=1, then go to IDLE.
  - RESP_ERR: err=1, then go to IDLE.
- Excitation per lane i, computed from q_fb sampled at command accept:
  - msk=0 → {s,r}=00
  - tgt=1, q=0 → 10
  - tgt=0, q=1 → 01
  - tgt==q → 00 (hold)
- {s[i],r[i]}==11 is forbidden in every state, including across reset.
- s and r are 0 in every state except DRIVE.
- cnt has width $clog2(TIMEOUT+1). It clears on entry to CHECK and saturates; it does not wrap.
- cmd_mask=0 or cmd_data equal to the current q: DRIVE outputs all zeros, CHECK passes first cycle, done pulses.
- No retry on mismatch; err is terminal for that command. tgt and msk are not updated until the next accept.
- Asynchronous reset at any point, mid-command included:
  - State goes to IDLE and the command is dropped with neither done nor err.
  - s=0, r=0, done=0, err=0, cmd_ready=0, cnt=0, tgt=0, msk=0.
  - cmd_ready rises at the first clk edge after rst_n deasserts.

## Timing
- Cycle 0: accept edge.
- Cycle 1: DRIVE, s/r valid.
- Cycle 2: first CHECK. A bank with one-cycle q latency shows the new q here.
- Cycle 3: done pulse.
- Cycle 4: cmd_ready high again.
- Minimum command-to-command spacing is 4 cycles.
- Worst case: err in cycle 2+TIMEOUT.
- cmd_ready is a registered function of state. cmd_valid held during busy cycles is ignored and is not queued.
- done and err are mutually exclusive and each lasts exactly one cycle.
- q_fb is sampled synchronously only; the block does not synchronise it.

## Structure
- Package sr_drive_pkg holds:
  - typedef enum state_t {IDLE, DRIVE, CHECK, RESP_OK, RESP_ERR}
  - typedef enum logic [1:0] excite_t {EX_HOLD=2'b00, EX_RESET=2'b01, EX_SET=2'b10}
  - function to_excite(tgt, q, msk), the single source of the excitation rule
- Sub-module sr_excite: combinational, per-lane array mapping tgt/q/msk to s/r via to_excite. It is instanced once with WIDTH lanes.
- The bench pairs this block with WIDTH SR flip-flops as the feedback model. It also provides a stuck-q model for error tests.

## Test plan
- Reset, then WIDTH=8 bank at q=0x00. Command data=0xA5, mask=0xFF → cycle 1: s=0xA5, r=0x00; q_fb=0xA5 in cycle 2; done in cycle 3; cmd_ready high in cycle 4.
- With q=0xA5, command data=0x0F, mask=0xFF → DRIVE s=0x0A, r=0xA0; done in cycle 3.
- With q=0xA5, command data=0x00, mask=0x0F → s=0x00, r=0x05; q ends 0xA0; upper nibble untouched.
- Command data=q or mask=0x00 → s=r=0 throughout; done in cycle 3, no err.
- Lane 3 stuck at 0, TIMEOUT=4, command data=0x08 → s=0x08 in cycle 1; err pulses once in cycle 6; no done.
- Reset asserted during CHECK → s/r/done/err immediately 0; no pulse afterward; the next command after release completes normally.
- All scenarios: assertion that (s & r) == 0 every cycle.
